// File: rtl/std_counter_bank_pkg.sv
// Shared types for the counter bank: overflow policy and clock descriptor.
package std_counter_bank_pkg;

  typedef enum logic {
    STD_COUNTER_WRAP,
    STD_COUNTER_SATURATE
  } std_counter_mode_t;

  typedef struct packed {
    logic [31:0] period_ps;
  } std_clock_info_t;

endpackage

// File: rtl/std_counter_channel.sv
// One up/down counter channel with bounded wrap/saturate arithmetic and
// registered overflow pulse / sticky flag; value visible one cycle after the edge.
module std_register
  import std_counter_bank_pkg::*;
#(
  parameter std_clock_info_t  CLOCK_INFO  = '0,
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) q <= RESET_VALUE;
    else     q <= d;
  end
endmodule

module std_counter_channel
  import std_counter_bank_pkg::*;
#(
  parameter std_clock_info_t   CLOCK_INFO   = '0,
  parameter int                WIDTH        = 8,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter std_counter_mode_t MODE         = STD_COUNTER_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             down,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] max,
  input  logic             clear,
  input  logic             load_enable,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             at_max,
  output logic             at_zero,
  output logic             overflow,
  output logic             overflow_sticky
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] value_d, value_q;
  logic [1:0]       flags_d, flags_q;
  logic             event_c;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff, wrap_up, wrap_dn;

  always_comb begin
    sum     = {1'b0, value_q} + {1'b0, step};
    diff    = value_q - step;
    // Both wrap results only need the low WIDTH bits, so modular math suffices.
    wrap_up = value_q + step + ~max;
    wrap_dn = value_q - step + max + ONE;
    value_d = value_q;
    event_c = 1'b0;
    if (clear) begin
      value_d = RESET_VECTOR;
    end else if (load_enable) begin
      value_d = load_value;
    end else if (enable) begin
      if (step == '0) begin
        if (value_q > max) value_d = max;
      end else if (!down) begin
        if (sum <= {1'b0, max}) begin
          value_d = sum[WIDTH-1:0];
        end else begin
          event_c = 1'b1;
          value_d = (MODE == STD_COUNTER_WRAP) ? wrap_up : max;
        end
      end else begin
        if (value_q >= step) begin
          value_d = (diff > max) ? max : diff;
        end else begin
          event_c = 1'b1;
          value_d = (MODE == STD_COUNTER_WRAP) ? wrap_dn : '0;
        end
      end
    end
    flags_d[0] = event_c;
    flags_d[1] = clear ? 1'b0 : (flags_q[1] | event_c);
  end

  std_register #(.CLOCK_INFO(CLOCK_INFO), .WIDTH(WIDTH), .RESET_VALUE(RESET_VECTOR)) u_value (
    .clk(clk), .rst(rst), .d(value_d), .q(value_q)
  );

  std_register #(.CLOCK_INFO(CLOCK_INFO), .WIDTH(2), .RESET_VALUE(2'b00)) u_flags (
    .clk(clk), .rst(rst), .d(flags_d), .q(flags_q)
  );

  assign value           = value_q;
  assign at_max          = (value_q == max);
  assign at_zero         = (value_q == '0);
  assign overflow        = flags_q[0];
  assign overflow_sticky = flags_q[1];
endmodule

// File: rtl/std_counter_bank.sv
// Bank of independent up/down counters; each channel updates one cycle after
// its enabling edge. The bank only slices packed ports into per-channel instances.
module std_counter_bank
  import std_counter_bank_pkg::*;
#(
  parameter std_clock_info_t   CLOCK_INFO   = '0,
  parameter int                CHANNELS     = 4,
  parameter int                WIDTH        = 8,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter std_counter_mode_t MODE         = STD_COUNTER_WRAP
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CHANNELS-1:0]              enable,
  input  logic [CHANNELS-1:0]              down,
  input  logic [CHANNELS-1:0][WIDTH-1:0]   step,
  input  logic [CHANNELS-1:0][WIDTH-1:0]   max,
  input  logic [CHANNELS-1:0]              clear,
  input  logic [CHANNELS-1:0]              load_enable,
  input  logic [CHANNELS-1:0][WIDTH-1:0]   load_value,
  output logic [CHANNELS-1:0][WIDTH-1:0]   value,
  output logic [CHANNELS-1:0]              at_max,
  output logic [CHANNELS-1:0]              at_zero,
  output logic [CHANNELS-1:0]              overflow,
  output logic [CHANNELS-1:0]              overflow_sticky
);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    std_counter_channel #(
      .CLOCK_INFO(CLOCK_INFO), .WIDTH(WIDTH), .RESET_VECTOR(RESET_VECTOR), .MODE(MODE)
    ) u_ch (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable[c]),
      .down            (down[c]),
      .step            (step[c]),
      .max             (max[c]),
      .clear           (clear[c]),
      .load_enable     (load_enable[c]),
      .load_value      (load_value[c]),
      .value           (value[c]),
      .at_max          (at_max[c]),
      .at_zero         (at_zero[c]),
      .overflow        (overflow[c]),
      .overflow_sticky (overflow_sticky[c])
    );
  end
endmodule
